// File: rtl/fifo_pair_reader_if.sv
// Bundles the FIFO read port and the single-lane output stream of the pair reader.
// master = the reader itself, slave = the FIFO/FIR side driving it.
interface fifo_pair_reader_if #(
   parameter int DWIDTH = 24
);
   logic              fifo_empty;
   logic [DWIDTH-1:0] fifo_data1;
   logic [DWIDTH-1:0] fifo_data2;
   logic              fifo_rd;
   logic              out_valid;
   logic              out_ready;
   logic [DWIDTH-1:0] out_data;
   logic              out_chan;

   modport master (
      input  fifo_empty, fifo_data1, fifo_data2, out_ready,
      output fifo_rd, out_valid, out_data, out_chan
   );

   modport slave (
      output fifo_empty, fifo_data1, fifo_data2, out_ready,
      input  fifo_rd, out_valid, out_data, out_chan
   );
endinterface

// File: rtl/fifo_pair_reader.sv
// Pops {data1, data2} pairs from the dual-channel FIFO and serialises them onto one
// valid/ready lane, channel 1 then channel 2, with no bubble between back-to-back pairs.
module fifo_pair_reader #(
   parameter int DWIDTH  = 24,
   parameter int COUNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   fifo_pair_reader_if.master  bus,
   output logic [COUNT_W-1:0]  pair_count,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, CH1, CH2} state_t;

   state_t              state_q, state_d;
   logic [DWIDTH-1:0]   hold1_q, hold1_d;
   logic [DWIDTH-1:0]   hold2_q, hold2_d;
   logic [DWIDTH-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_chan_q, out_chan_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                pop;

   always_comb begin
      pop = ~rst & ~flush & ~bus.fifo_empty &
            ((state_q == IDLE) | ((state_q == CH2) & bus.out_ready));

      state_d = state_q;
      hold1_d = hold1_q;
      hold2_d = hold2_q;
      count_d = count_q;

      if (pop) begin
         hold1_d = bus.fifo_data1;
         hold2_d = bus.fifo_data2;
      end

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (pop) state_d = CH1;
            CH1:  if (bus.out_ready) state_d = CH2;
            CH2: begin
               if (bus.out_ready) begin
                  count_d = count_q + COUNT_W'(1);
                  state_d = bus.fifo_empty ? IDLE : CH1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Outputs are registered from the next state so each beat appears the cycle after its decision.
      out_valid_d = (state_d != IDLE);
      out_chan_d  = (state_d == CH2);
      case (state_d)
         CH1:     out_data_d = hold1_d;
         CH2:     out_data_d = hold2_d;
         default: out_data_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hold1_q     <= '0;
         hold2_q     <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_chan_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold1_q     <= hold1_d;
         hold2_q     <= hold2_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_chan_q  <= out_chan_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.fifo_rd   = pop;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign pair_count    = count_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_pair_reader.sv
// Directed bench for fifo_pair_reader: a queue-of-beats model predicts the stream every cycle,
// and literal expectations pin the key latency, backpressure, flush and wrap points.
module tb_fifo_pair_reader;

   localparam int DW = 24;
   localparam int CW = 4;

   logic          clk = 1'b1;
   logic          rst;
   logic          flush;
   logic [CW-1:0] pair_count;
   logic          busy;

   fifo_pair_reader_if #(.DWIDTH(DW)) bus ();

   fifo_pair_reader #(.DWIDTH(DW), .COUNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .bus        (bus),
      .pair_count (pair_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
   } pair_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          chan;
   } beat_t;

   pair_t fifo_q[$];
   beat_t beats[$];
   int    model_count = 0;
   bit    armed = 1'b0;
   int    checks = 0;
   int    errors = 0;

   logic          smp_rst, smp_flush, smp_ready, smp_dut_rd, smp_exp_rd;
   logic [DW-1:0] smp_d1, smp_d2;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic f, input logic ready);
      rst           = r;
      flush         = f;
      bus.out_ready = ready;
   endtask

   task automatic refreshFifo();
      if (fifo_q.size() == 0) begin
         bus.fifo_empty = 1'b1;
         bus.fifo_data1 = '0;
         bus.fifo_data2 = '0;
      end else begin
         bus.fifo_empty = 1'b0;
         bus.fifo_data1 = fifo_q[0].d1;
         bus.fifo_data2 = fifo_q[0].d2;
      end
   endtask

   task automatic pushPair(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      pair_t p;
      p.d1 = d1;
      p.d2 = d2;
      fifo_q.push_back(p);
      refreshFifo();
   endtask

   // The stream is just a queue of pending beats: a pop appends two, a handshake consumes one.
   task automatic modelStep();
      beat_t b;
      if (smp_rst) begin
         beats.delete();
         model_count = 0;
         armed = 1'b1;
      end else if (smp_flush) begin
         beats.delete();
      end else begin
         if (beats.size() > 0 && smp_ready) begin
            if (beats[0].chan) model_count++;
            void'(beats.pop_front());
         end
         if (smp_exp_rd) begin
            b.data = smp_d1; b.chan = 1'b0; beats.push_back(b);
            b.data = smp_d2; b.chan = 1'b1; beats.push_back(b);
         end
      end
      if (smp_dut_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
   endtask

   task automatic runCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         modelStep();
         #1;
         refreshFifo();
      end
   endtask

   // A pop is due whenever the stream would be left with nothing after this cycle.
   always @(negedge clk) begin
      smp_rst    = rst;
      smp_flush  = flush;
      smp_ready  = bus.out_ready;
      smp_dut_rd = bus.fifo_rd;
      smp_d1     = bus.fifo_data1;
      smp_d2     = bus.fifo_data2;
      smp_exp_rd = !rst && !flush && !bus.fifo_empty &&
                   (beats.size() == 0 || (beats.size() == 1 && bus.out_ready));
      if (armed) begin
         checkOutput("fifo_rd", bus.fifo_rd, smp_exp_rd);
         if (beats.size() > 0) begin
            checkOutput("out_valid", bus.out_valid, 1);
            checkOutput("out_data", bus.out_data, beats[0].data);
            checkOutput("out_chan", bus.out_chan, beats[0].chan);
            checkOutput("busy", busy, 1);
         end else begin
            checkOutput("out_valid", bus.out_valid, 0);
            checkOutput("out_data", bus.out_data, 0);
            checkOutput("out_chan", bus.out_chan, 0);
            checkOutput("busy", busy, 0);
         end
         checkOutput("pair_count", pair_count, model_count % (1 << CW));
      end
   end

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      refreshFifo();
      runCycles(3);

      $display("[TB] single pair latency");
      applyStimulus(1'b0, 1'b0, 1'b1);
      pushPair(24'h000111, 24'h000222);
      @(negedge clk); checkOutput("single_rd_c0", bus.fifo_rd, 1);
      runCycles(1);
      @(negedge clk); checkOutput("single_data_c1", bus.out_data, 24'h000111);
                      checkOutput("single_chan_c1", bus.out_chan, 0);
      runCycles(1);
      @(negedge clk); checkOutput("single_data_c2", bus.out_data, 24'h000222);
                      checkOutput("single_chan_c2", bus.out_chan, 1);
      runCycles(1);
      @(negedge clk); checkOutput("single_count_c3", pair_count, 1);
                      checkOutput("single_valid_c3", bus.out_valid, 0);

      $display("[TB] three back-to-back pairs");
      runCycles(1);
      pushPair(24'h10, 24'h11);
      pushPair(24'h20, 24'h21);
      pushPair(24'h30, 24'h31);
      @(negedge clk); checkOutput("b2b_rd_c0", bus.fifo_rd, 1);
      runCycles(2);
      @(negedge clk); checkOutput("b2b_rd_c2", bus.fifo_rd, 1);
                      checkOutput("b2b_data_c2", bus.out_data, 24'h11);
      runCycles(1);
      @(negedge clk); checkOutput("b2b_data_c3", bus.out_data, 24'h20);
      runCycles(1);
      @(negedge clk); checkOutput("b2b_rd_c4", bus.fifo_rd, 1);
      runCycles(2);
      @(negedge clk); checkOutput("b2b_data_c6", bus.out_data, 24'h31);
      runCycles(1);
      @(negedge clk); checkOutput("b2b_valid_c7", bus.out_valid, 0);
                      checkOutput("b2b_count_c7", pair_count, 4);

      $display("[TB] reset in the middle of CH1");
      runCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      pushPair(24'h00ABCD, 24'h00DCBA);
      runCycles(2);
      @(negedge clk); checkOutput("rst_hold1", bus.out_data, 24'h00ABCD);
      runCycles(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk); checkOutput("rst_valid", bus.out_valid, 0);
                      checkOutput("rst_data", bus.out_data, 0);
                      checkOutput("rst_count", pair_count, 0);
                      checkOutput("rst_busy", busy, 0);
                      checkOutput("rst_rd", bus.fifo_rd, 0);

      $display("[TB] backpressure held in CH1");
      runCycles(1);
      pushPair(24'h0000A1, 24'h0000A2);
      pushPair(24'h0000B1, 24'h0000B2);
      runCycles(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); checkOutput("bp_hold_data", bus.out_data, 24'h0000A1);
                         checkOutput("bp_no_rd", bus.fifo_rd, 0);
         runCycles(1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      runCycles(1);
      @(negedge clk); checkOutput("bp_resume_data", bus.out_data, 24'h0000A2);
                      checkOutput("bp_resume_rd", bus.fifo_rd, 1);
      runCycles(1);
      @(negedge clk); checkOutput("bp_next_pair", bus.out_data, 24'h0000B1);
      runCycles(3);

      $display("[TB] flush during CH2");
      pushPair(24'h0000C1, 24'h0000C2);
      pushPair(24'h0000D1, 24'h0000D2);
      runCycles(2);
      applyStimulus(1'b0, 1'b1, 1'b1);
      @(negedge clk); checkOutput("flush_no_rd", bus.fifo_rd, 0);
      runCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk); checkOutput("flush_idle", bus.out_valid, 0);
                      checkOutput("flush_count", pair_count, 2);
                      checkOutput("flush_resume_rd", bus.fifo_rd, 1);
      runCycles(4);

      $display("[TB] pair counter wrap");
      applyStimulus(1'b1, 1'b0, 1'b1);
      runCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 17; k++) begin
         pushPair(DW'(k * 16 + 1), DW'(k * 16 + 2));
      end
      runCycles(31);
      @(negedge clk); checkOutput("wrap_count_15", pair_count, 15);
      runCycles(2);
      @(negedge clk); checkOutput("wrap_count_0", pair_count, 0);
      runCycles(2);
      @(negedge clk); checkOutput("wrap_count_1", pair_count, 1);
      runCycles(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_pair_reader.md
Name: fifo_pair_reader

Overview:
- Consumer end of the dual-channel sample FIFO. Pops one {data1, data2} pair per FIFO read and serialises it onto a single-lane valid/ready stream, channel 1 first, then channel 2, each tagged with a channel bit.
- Sits between the FIFO read port and the FIR datapath. Keeps the filter input at one sample per beat, with no bubble between back-to-back pairs.

Parameters:
- DWIDTH, 24, sample width of each channel and of out_data
- COUNT_W, 16, width of the completed-pair counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort: drop any held pair, return to IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_data1  in  DWIDTH  FIFO head word, channel 1 (valid combinationally while fifo_empty=0)
- fifo_data2  in  DWIDTH  FIFO head word, channel 2
- fifo_rd  out  1  pop strobe to FIFO, combinational, one cycle per pair
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from FIR
- out_data  out  DWIDTH  stream sample
- out_chan  out  1  0 = channel 1 sample, 1 = channel 2 sample
- pair_count  out  COUNT_W  number of pairs fully delivered, wraps modulo 2^COUNT_W
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - state=IDLE; hold1=hold2=0; pair_count=0.
  - Outputs: out_valid=0, out_data=0, out_chan=0, busy=0, fifo_rd=0.
  - rst has priority over flush and over every handshake; a pair in progress is discarded.
- State machine, three states:
  - IDLE: out_valid=0. If fifo_empty=0 and flush=0: fifo_rd=1, capture hold1<=fifo_data1 and hold2<=fifo_data2, go to CH1.
  - CH1: out_valid=1, out_data=hold1, out_chan=0. If out_ready=1, go to CH2; otherwise hold.
  - CH2: out_valid=1, out_data=hold2, out_chan=1. If out_ready=1, increment pair_count. Then:
    - if fifo_empty=0: fifo_rd=1, capture the new pair, go to CH1 (no bubble);
    - otherwise go to IDLE.
    - If out_ready=0, hold.
- fifo_rd = ~flush & ~fifo_empty & (state==IDLE | (state==CH2 & out_ready)). Never asserted while fifo_empty=1. At most one pop per cycle.
- Latency:
  - Pair visible with fifo_empty=0 in cycle t while IDLE: first beat has out_valid=1 at t+1.
  - Sustained throughput: 2 beats per pair with out_ready held at 1.
- Stream rules:
  - out_data and out_chan are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on flush or rst.
  - out_data = 0 in IDLE.
- flush=1 (rst=0):
  - Next state is IDLE; hold registers are unchanged but ignored.
  - No fifo_rd that cycle; no pair_count increment even if out_ready=1 in CH2.
  - The FIFO contents are untouched; draining resumes after flush deasserts.
- pair_count: increments by 1 only on the CH2 handshake; wraps from 2^COUNT_W-1 to 0.
- FIFO goes empty mid-pair: the held pair still completes fully. No partial pairs are ever emitted.

Test Plan:
- rst mid-CH1 with out_ready=0, hold1=24'h00ABCD -> next cycle out_valid=0, out_data=0, pair_count=0, busy=0, fifo_rd=0.
- FIFO head (24'h000111, 24'h000222), fifo_empty=0 from cycle 0, out_ready=1 -> fifo_rd=1 at cycle 0. Cycle 1: out_data=24'h000111, out_chan=0. Cycle 2: out_data=24'h000222, out_chan=1. pair_count=1 at cycle 3.
- Three pairs queued (0x10/0x11, 0x20/0x21, 0x30/0x31), out_ready=1 -> six consecutive valid beats 0x10,0x11,0x20,0x21,0x30,0x31 with no gap. fifo_rd pulses at cycles 0, 2, 4. Then IDLE, pair_count=3.
- Backpressure: out_ready=0 for 5 cycles in CH1 -> out_data held at hold1, no fifo_rd. After out_ready=1, the beat sequence resumes unchanged.
- flush in CH2 with out_ready=1 and fifo_empty=0 -> no fifo_rd, pair_count unchanged, IDLE next. A pop occurs the cycle after flush deasserts.
- COUNT_W=4: deliver 17 pairs -> pair_count reads 15 after pair 15, 0 after pair 16, 1 after pair 17.
